// File: rtl/mem_wb_load.sv
// ---------------------------------------------------------------------------
// mem_wb_load
//   MEM->WB stage, read side of the data-memory path. Loads issue a level
//   read request to data memory and hold the pipeline (o_stall) until
//   i_dm_rvalid returns. The returned word is aligned and sign/zero-extended,
//   then registered into WB together with the latched rd and enables.
//   Non-loads pass i_alu_out_MEM into WB in one cycle. The WB data output
//   also feeds the WB->EX forwarding path.
//
// Parameters
//   TIMEOUT        WAIT cycles before a pending load is aborted (0 = never)
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   i_mem_valid          MEM stage holds a valid instruction
//   i_is_load_MEM[2:0]   000 none,001 LW,010 LH,011 LB,100 LHU,101 LBU,
//                        110 FLW,111 reserved (treated as none)
//   i_alu_out_MEM[31:0]  load byte address, or result for non-loads
//   i_rd_addr_MEM[5:0]   destination register ([5] selects FP file)
//   i_wb_en_MEM          integer writeback enable
//   i_fwb_en_MEM         FP writeback enable
//   o_dm_req             DM read request, held until i_dm_rvalid
//   o_dm_addr[31:0]      DM word address
//   i_dm_rdata[31:0]     DM read data, qualified by i_dm_rvalid
//   i_dm_rvalid          DM read data valid (single-cycle pulse)
//   o_stall              freeze IF..MEM this cycle
//   o_wb_data_WB[31:0]   WB write data / WB forward value
//   o_rd_addr_WB[5:0]    WB destination register
//   o_wb_en_WB           integer writeback strobe
//   o_fwb_en_WB          FP writeback strobe
//   o_load_err           single-cycle pulse on misaligned load or timeout
// ---------------------------------------------------------------------------
module mem_wb_load #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_mem_valid,
   input  logic [2:0]  i_is_load_MEM,
   input  logic [31:0] i_alu_out_MEM,
   input  logic [5:0]  i_rd_addr_MEM,
   input  logic        i_wb_en_MEM,
   input  logic        i_fwb_en_MEM,
   output logic        o_dm_req,
   output logic [31:0] o_dm_addr,
   input  logic [31:0] i_dm_rdata,
   input  logic        i_dm_rvalid,
   output logic        o_stall,
   output logic [31:0] o_wb_data_WB,
   output logic [5:0]  o_rd_addr_WB,
   output logic        o_wb_en_WB,
   output logic        o_fwb_en_WB,
   output logic        o_load_err
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam logic [2:0] LD_NONE = 3'b000;
   localparam logic [2:0] LD_LW   = 3'b001;
   localparam logic [2:0] LD_LH   = 3'b010;
   localparam logic [2:0] LD_LB   = 3'b011;
   localparam logic [2:0] LD_LHU  = 3'b100;
   localparam logic [2:0] LD_LBU  = 3'b101;
   localparam logic [2:0] LD_FLW  = 3'b110;
   localparam logic [2:0] LD_RSVD = 3'b111;

   // Counter only needs to reach TIMEOUT; with TIMEOUT=0 it is a dummy bit.
   localparam int unsigned CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
   localparam bit         TO_EN  = (TIMEOUT != 0);

   // State
   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;

   // Load context latched at issue (MEM inputs are not trusted during WAIT)
   logic [31:2]   r_waddr;
   logic [1:0]    r_off;
   logic [2:0]    r_type;
   logic [5:0]    r_lrd;
   logic          r_lwb;
   logic          r_lfwb;

   // WB stage registers
   logic [31:0]   r_wb_data;
   logic [5:0]    r_rd;
   logic          r_wb_en;
   logic          r_fwb_en;
   logic          r_load_err;

   // Combinational decode
   logic          w_is_load;
   logic          w_misalign;
   logic          w_issue;
   logic          w_wait;
   logic          w_done;
   logic          w_timeout;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_ext;

   assign w_is_load = i_mem_valid &&
                      (i_is_load_MEM != LD_NONE) && (i_is_load_MEM != LD_RSVD);

   always_comb begin
      w_misalign = 1'b0;
      case (i_is_load_MEM)
         LD_LW, LD_FLW: w_misalign = (i_alu_out_MEM[1:0] != 2'b00);
         LD_LH, LD_LHU: w_misalign = i_alu_out_MEM[0];
         default:       w_misalign = 1'b0;
      endcase
   end

   assign w_wait    = (r_state == S_WAIT);
   assign w_issue   = (r_state == S_IDLE) && w_is_load && !w_misalign;
   // Response arriving on the timeout cycle still completes the load.
   assign w_done    = w_wait && i_dm_rvalid;
   assign w_timeout = TO_EN && w_wait && (r_cnt == TO_VAL) && !i_dm_rvalid;

   // Request is combinational on the issue cycle so DM sees it one cycle
   // earlier; in WAIT the address comes from the latched copy.
   assign o_dm_req  = w_issue || w_wait;
   assign o_dm_addr = w_issue ? {i_alu_out_MEM[31:2], 2'b00} :
                      w_wait  ? {r_waddr, 2'b00} : 32'h0;
   assign o_stall   = w_issue || (w_wait && !i_dm_rvalid && !w_timeout);

   // Lane select within the returned word
   assign w_byte = i_dm_rdata[{r_off, 3'b000} +: 8];
   assign w_half = i_dm_rdata[{r_off[1], 4'b0000} +: 16];

   always_comb begin
      w_ext = i_dm_rdata;
      case (r_type)
         LD_LH:   w_ext = {{16{w_half[15]}}, w_half};
         LD_LHU:  w_ext = {16'h0, w_half};
         LD_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
         LD_LBU:  w_ext = {24'h0, w_byte};
         default: w_ext = i_dm_rdata;      // LW / FLW
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_waddr    <= '0;
         r_off      <= '0;
         r_type     <= LD_NONE;
         r_lrd      <= '0;
         r_lwb      <= 1'b0;
         r_lfwb     <= 1'b0;
         r_wb_data  <= '0;
         r_rd       <= '0;
         r_wb_en    <= 1'b0;
         r_fwb_en   <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_load_err <= 1'b0;
         if (r_state == S_IDLE) begin
            if (w_is_load) begin
               // Loads never retire from IDLE: strobes stay low.
               r_wb_en  <= 1'b0;
               r_fwb_en <= 1'b0;
               if (w_misalign) begin
                  r_load_err <= 1'b1;
               end else begin
                  r_waddr <= i_alu_out_MEM[31:2];
                  r_off   <= i_alu_out_MEM[1:0];
                  r_type  <= i_is_load_MEM;
                  r_lrd   <= i_rd_addr_MEM;
                  // FLW targets the FP file only.
                  r_lwb   <= (i_is_load_MEM == LD_FLW) ? 1'b0 : i_wb_en_MEM;
                  r_lfwb  <= i_fwb_en_MEM;
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
               end
            end else begin
               r_wb_data <= i_alu_out_MEM;
               r_rd      <= i_rd_addr_MEM;
               r_wb_en   <= i_wb_en_MEM  & i_mem_valid;
               r_fwb_en  <= i_fwb_en_MEM & i_mem_valid;
            end
         end else begin
            if (w_done) begin
               r_wb_data <= w_ext;
               r_rd      <= r_lrd;
               r_wb_en   <= r_lwb;
               r_fwb_en  <= r_lfwb;
               r_cnt     <= '0;
               r_state   <= S_IDLE;
            end else if (w_timeout) begin
               r_wb_en    <= 1'b0;
               r_fwb_en   <= 1'b0;
               r_load_err <= 1'b1;
               r_cnt      <= '0;
               r_state    <= S_IDLE;
            end else begin
               r_wb_en  <= 1'b0;
               r_fwb_en <= 1'b0;
               r_cnt    <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign o_wb_data_WB = r_wb_data;
   assign o_rd_addr_WB = r_rd;
   assign o_wb_en_WB   = r_wb_en;
   assign o_fwb_en_WB  = r_fwb_en;
   assign o_load_err   = r_load_err;

endmodule

// File: tb/tb_mem_wb_load.sv
// Bench for mem_wb_load: directed cases followed by randomized instruction
// stream. Retirement events are predicted into a queue at issue time and a
// separate monitor compares them whenever the DUT strobes WB or load_err.
module tb_mem_wb_load;
   localparam int TO = 4;

   logic        clk, rst;
   logic        mem_valid;
   logic [2:0]  is_load;
   logic [31:0] alu_out;
   logic [5:0]  rd_addr;
   logic        wb_en, fwb_en;
   logic        dm_req;
   logic [31:0] dm_addr;
   logic [31:0] dm_rdata;
   logic        dm_rvalid;
   logic        stall;
   logic [31:0] wb_data_WB;
   logic [5:0]  rd_addr_WB;
   logic        wb_en_WB, fwb_en_WB, load_err;

   mem_wb_load #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_mem_valid(mem_valid), .i_is_load_MEM(is_load), .i_alu_out_MEM(alu_out),
      .i_rd_addr_MEM(rd_addr), .i_wb_en_MEM(wb_en), .i_fwb_en_MEM(fwb_en),
      .o_dm_req(dm_req), .o_dm_addr(dm_addr), .i_dm_rdata(dm_rdata),
      .i_dm_rvalid(dm_rvalid), .o_stall(stall), .o_wb_data_WB(wb_data_WB),
      .o_rd_addr_WB(rd_addr_WB), .o_wb_en_WB(wb_en_WB), .o_fwb_en_WB(fwb_en_WB),
      .o_load_err(load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] data;
      logic [5:0]  rd;
      logic        wb;
      logic        fwb;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem [256];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference load result from plain shifts and masks.
   function automatic logic [31:0] ld_value(input logic [2:0] ty, input logic [31:0] a,
                                            input logic [31:0] w);
      logic [31:0] bv, hv;
      int          b;
      b  = int'(a[1:0]);
      bv = (w >> (8 * b)) & 32'hFF;
      hv = (w >> (16 * (b / 2))) & 32'hFFFF;
      case (ty)
         3'd1, 3'd6: return w;
         3'd2:       return (hv >= 32'h8000) ? hv + 32'hFFFF_0000 : hv;
         3'd4:       return hv;
         3'd3:       return (bv >= 32'h80) ? bv + 32'hFFFF_FF00 : bv;
         3'd5:       return bv;
         default:    return 32'h0;
      endcase
   endfunction

   // Monitor: every WB strobe or error pulse must match the oldest prediction.
   always @(negedge clk) begin
      if (!rst && (wb_en_WB || fwb_en_WB || load_err)) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: wb=%b fwb=%b err=%b data=%h with empty queue",
                     wb_en_WB, fwb_en_WB, load_err, wb_data_WB);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("evt_err", 32'(load_err), 32'(e.err));
            check("evt_wb_en", 32'(wb_en_WB), 32'(e.wb));
            check("evt_fwb_en", 32'(fwb_en_WB), 32'(e.fwb));
            if (!e.err) begin
               check("evt_data", wb_data_WB, e.data);
               check("evt_rd", 32'(rd_addr_WB), 32'(e.rd));
            end
         end
      end
   end

   // Present one instruction (called at posedge+1) and run it to retirement.
   // d = WAIT cycle on which the response arrives; d > TO means never.
   task automatic run_instr(input logic mv, input logic [2:0] ty, input logic [31:0] a,
                            input logic [5:0] rd, input logic wb, input logic fwb,
                            input int d);
      logic  is_ld, mis, wbe;
      int    stalls, exp_stalls;
      logic  last;
      exp_t  e;
      logic [31:0] w;
      mem_valid = mv; is_load = ty; alu_out = a; rd_addr = rd; wb_en = wb; fwb_en = fwb;
      // Stray response while idle must be ignored.
      dm_rvalid = ($urandom_range(0, 3) == 0);
      dm_rdata  = $urandom;
      is_ld = mv && (ty != 3'd0) && (ty != 3'd7);
      mis   = is_ld && ((((ty == 3'd1) || (ty == 3'd6)) && (a[1:0] != 2'b00)) ||
                        (((ty == 3'd2) || (ty == 3'd4)) && a[0]));
      if (!is_ld || mis) begin
         if (mis) begin
            e.err = 1'b1; e.data = '0; e.rd = '0; e.wb = 1'b0; e.fwb = 1'b0;
            q.push_back(e);
         end else if (mv && (wb || fwb)) begin
            e.err = 1'b0; e.data = a; e.rd = rd; e.wb = wb; e.fwb = fwb;
            q.push_back(e);
         end
         @(negedge clk);
         check("idle_stall", 32'(stall), 32'd0);
         check("idle_dm_req", 32'(dm_req), 32'd0);
         @(posedge clk); #1;
         dm_rvalid = 1'b0;
      end else begin
         w   = mem[a[9:2]];
         wbe = (ty == 3'd6) ? 1'b0 : wb;
         if (d <= TO) begin
            if (wbe || fwb) begin
               e.err = 1'b0; e.data = ld_value(ty, a, w); e.rd = rd; e.wb = wbe; e.fwb = fwb;
               q.push_back(e);
            end
         end else begin
            e.err = 1'b1; e.data = '0; e.rd = '0; e.wb = 1'b0; e.fwb = 1'b0;
            q.push_back(e);
         end
         stalls = 0;
         @(negedge clk);
         check("issue_dm_req", 32'(dm_req), 32'd1);
         check("issue_dm_addr", dm_addr, a & 32'hFFFF_FFFC);
         if (stall) stalls++;
         @(posedge clk); #1;
         for (int k = 0; k < 64; k++) begin
            // Frozen-pipeline inputs are scrambled; the DUT must use its latch.
            mem_valid = 1'($urandom); is_load = 3'($urandom); alu_out = $urandom;
            rd_addr = 6'($urandom); wb_en = 1'($urandom); fwb_en = 1'($urandom);
            dm_rvalid = (k == d);
            dm_rdata  = (k == d) ? w : $urandom;
            last = (k == d) || (k == TO);
            @(negedge clk);
            if (!last) check("wait_dm_req", 32'(dm_req), 32'd1);
            if (stall) stalls++;
            @(posedge clk); #1;
            if (last) break;
         end
         dm_rvalid = 1'b0;
         exp_stalls = (d <= TO) ? 1 + d : 1 + TO;
         check("stall_cycles", 32'(stalls), 32'(exp_stalls));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mem_valid = 0; is_load = 0; alu_out = 0; rd_addr = 0;
      wb_en = 0; fwb_en = 0; dm_rdata = 0; dm_rvalid = 0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[8'h40] = 32'h80FF_0000;
      mem[8'h80] = 32'h9ABC_1234;
      #12;
      check("rst_dm_req", 32'(dm_req), 32'd0);
      check("rst_dm_addr", dm_addr, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_wb_data", wb_data_WB, 32'd0);
      check("rst_rd", 32'(rd_addr_WB), 32'd0);
      check("rst_strobes", {29'd0, wb_en_WB, fwb_en_WB, load_err}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      run_instr(1, 3'd0, 32'h1234, 6'd5, 1, 0, 0);       // ALU pass
      run_instr(1, 3'd3, 32'h103, 6'd7, 1, 0, 0);        // LB sext
      run_instr(1, 3'd4, 32'h202, 6'd8, 1, 0, 2);        // LHU, 3 stall cycles
      run_instr(1, 3'd2, 32'h202, 6'd9, 1, 0, 2);        // LH
      run_instr(1, 3'd1, 32'h301, 6'd10, 1, 0, 0);       // misaligned LW
      run_instr(1, 3'd5, 32'h10, 6'd11, 1, 0, TO + 3);   // timeout
      run_instr(1, 3'd1, 32'h10, 6'd12, 1, 0, TO);       // rvalid wins on last cycle
      run_instr(1, 3'd6, 32'h20, 6'd33, 1, 1, 1);        // FLW: FP strobe only
      run_instr(1, 3'd7, 32'hCAFE, 6'd13, 1, 0, 0);      // reserved = pass
      run_instr(0, 3'd0, 32'hBEEF, 6'd14, 1, 1, 0);      // bubble: no strobe

      // Asynchronous reset during WAIT
      mem_valid = 1; is_load = 3'd1; alu_out = 32'h40; rd_addr = 6'd3; wb_en = 1; fwb_en = 0;
      @(negedge clk);
      check("ar_issue_req", 32'(dm_req), 32'd1);
      @(posedge clk); #1;
      mem_valid = 0; is_load = 0;
      #2 rst = 1'b1;
      #1;
      check("ar_dm_req_drop", 32'(dm_req), 32'd0);
      check("ar_stall_drop", 32'(stall), 32'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      dm_rvalid = 1'b1; dm_rdata = 32'h5555_AAAA;
      @(negedge clk);
      check("ar_late_req", 32'(dm_req), 32'd0);
      @(posedge clk); #1;
      dm_rvalid = 1'b0;
      @(negedge clk);
      check("ar_no_wb", {30'd0, wb_en_WB, fwb_en_WB}, 32'd0);
      @(posedge clk); #1;

      // Randomized stream
      for (int n = 0; n < 300; n++) begin
         logic [2:0]  ty;
         logic [31:0] a;
         int          d;
         ty = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         a  = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
         d  = ($urandom_range(0, 4) == 0) ? TO + 1 + $urandom_range(0, 2)
                                          : $urandom_range(0, TO);
         run_instr(($urandom_range(0, 7) != 0), ty, a, 6'($urandom),
                   1'($urandom), 1'($urandom), d);
      end

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
